imm_instr_encoder: RTL and testbench
====================================

Name: imm_instr_encoder

Overview:
Inverse of the immediate generator: packs decoded instruction fields (format, opcode, registers, functs, 32-bit immediate) into a 32-bit RV32I instruction word. Range-checks and scatters the immediate per format. Writes the result sequentially into instruction memory through an auto-incrementing write port. Used by the bench/boot loader to build programs from field descriptions instead of hand-assembled hex.

Parameters:
ADDR_W, 10, word-address width of the instruction memory write port
BASE_ADDR, 0, first word address written after reset or clear

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
clr  input  1  synchronous: reload address counter to BASE_ADDR, clear count/full/err; wins over a same-cycle accept
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle this cycle
fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6..7 illegal
opcode  input  7  placed at bits [6:0]
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  placed at bits [14:12]
funct7  input  7  R-type only, bits [31:25]
imm  input  32  signed byte offset/value (U: full 32-bit value, low 12 bits must be zero)
wr_en  output  1  memory write request
wr_addr  output  ADDR_W  word address
wr_data  output  32  encoded instruction
wr_ready  input  1  memory accepts write this cycle
count  output  ADDR_W+1  instructions successfully written since reset/clear
full  output  1  address space exhausted
err  output  1  sticky error flag
err_code  output  2  0=none 1=imm out of range 2=misaligned B/J offset 3=illegal fmt; holds first error

Behaviour:
- Accept when in_valid && in_ready. in_ready = !full && (!hold_valid || wr_ready).
- Encode combinationally; register into output holding stage: wr_en asserts the cycle after accept (latency 1).
- wr_en/wr_addr/wr_data held stable while wr_en && !wr_ready. Write completes on wr_en && wr_ready: wr_addr increments, count increments.
- Back-to-back: with wr_ready=1 continuously, one instruction per cycle.
- Field placement: R/I/S/B/U/J per RV32I base ISA. Unused fields forced to zero (e.g., rd in S/B, rs2 in I). Immediate bits scattered exactly inverse to the decoder.
- Range rules:
  - I/S: -2048..2047
  - B: -4096..4094, imm[0]=0
  - J: -1048576..1048574, imm[0]=0
  - U: imm[11:0]=0
  - Range check precedes alignment check.
- Errored bundle: still consumed (handshake completes); nothing written; no count or address increment. err sets; err_code latches only if err was clear.
- full: asserts when the write to address 2^ADDR_W-1 completes. in_ready then stays 0 until clr/rst. No wrap-around.
- Reset: wr_en=0, wr_addr=BASE_ADDR, wr_data=0, count=0, full=0, err=0, err_code=0, in_ready=1 (the cycle after rst deasserts).
- rst or clr during a pending write drops the write (wr_en=0 next cycle).
- Simultaneous accept and write-complete in the same cycle is legal: pipeline refills, no bubble.

Optional Feature:
IMM_ENCODER_SELFCHECK_EN
- Defined: instantiates immediate_generator on the holding-register wr_data. When wr_en is high, compares its imm_extended with the stored source imm; on mismatch, asserts extra output selfcheck_err (sticky, cleared by rst/clr).
- Undefined: selfcheck_err is tied 0; no decoder is instantiated.

Decomposition:
- Shared package rv32_pkg:
  - fmt codes FMT_R..FMT_J
  - err_code constants ERR_NONE/ERR_RANGE/ERR_ALIGN/ERR_FMT
  - opcode constants OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_OPIMM
- One natural sub-module: imm_field_packer (combinational format mux + range/alignment check returning word and error code). Handshake, counters and flags stay in the top module.

Test Plan:
- fmt=I, op=0010011, rd=5, rs1=10, f3=0, imm=-50 -> wr_data=FCE50293 at wr_addr=0, one cycle after accept, count=1.
- Back-to-back, wr_ready=1: S (rs1=10, rs2=5, f3=010, imm=32), B (rs1=1, rs2=2, imm=-8), U (op=0110111, rd=5, imm=DEADB000), J (op=1101111, rd=1, imm=-32) -> 02552023, FE208CE3, DEADB2B7, FE1FF0EF on consecutive cycles, addresses 1..4.
- I-type imm=2048 -> no wr_en, err=1, err_code=1; then B imm=-7 -> still err_code=1 (first error held); clr -> err=0.
- wr_ready held 0 for 3 cycles with pending write -> wr_en/wr_addr/wr_data stable, in_ready=0; release -> write completes, in_ready=1 same cycle.
- ADDR_W=2: write 4 valid instructions -> full=1, count=4, in_ready=0. fmt=7 input is ignored (no accept). clr -> wr_addr=0, full=0.
- rst asserted while wr_en=1 && wr_ready=0 -> next cycle wr_en=0, count=0, wr_addr=BASE_ADDR.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants: instruction formats, encoder error codes and opcodes.
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

endpackage

// File: rtl/imm_instr_encoder_if.sv
// Field-bundle input handshake and instruction-memory write port of the encoder.
// slave = encoder side; master = loader/memory side.
interface imm_instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imm_field_packer.sv
// Combinational RV32I field packer: scatters the immediate per format and
// range/alignment-checks it (range takes precedence over alignment).
module imm_field_packer
  import rv32_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic [1:0]  o_err_code
);

  logic signed [31:0] w_imm_s;
  assign w_imm_s = i_imm;

  always_comb begin
    o_word     = '0;
    o_err_code = ERR_NONE;
    case (i_fmt)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (w_imm_s < -32'sd2048 || w_imm_s > 32'sd2047) o_err_code = ERR_RANGE;
      end
      FMT_S: begin
        o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        if (w_imm_s < -32'sd2048 || w_imm_s > 32'sd2047) o_err_code = ERR_RANGE;
      end
      FMT_B: begin
        o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
        if (w_imm_s < -32'sd4096 || w_imm_s > 32'sd4094) o_err_code = ERR_RANGE;
        else if (i_imm[0])                                o_err_code = ERR_ALIGN;
      end
      FMT_U: begin
        o_word = {i_imm[31:12], i_rd, i_opcode};
        if (i_imm[11:0] != 12'd0) o_err_code = ERR_RANGE;
      end
      FMT_J: begin
        o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        if (w_imm_s < -32'sd1048576 || w_imm_s > 32'sd1048574) o_err_code = ERR_RANGE;
        else if (i_imm[0])                                      o_err_code = ERR_ALIGN;
      end
      default: o_err_code = ERR_FMT;
    endcase
  end

endmodule

// File: rtl/immediate_generator.sv
// Reference RV32I immediate decoder, used only when IMM_ENCODER_SELFCHECK_EN is defined
// (the whole module is compiled only in that build).
`ifdef IMM_ENCODER_SELFCHECK_EN
module immediate_generator
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm_extended
);

  always_comb begin
    imm_extended = '0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: imm_extended = {instr[31:12], 12'd0};
      OP_JAL:    imm_extended = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_BRANCH: imm_extended = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_STORE:  imm_extended = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      default:   imm_extended = {{21{instr[31]}}, instr[30:20]};
    endcase
  end

endmodule
`endif

// File: rtl/imm_instr_encoder.sv
// Field-bundle to RV32I encoder with a one-deep output holding stage feeding an
// auto-incrementing memory write port. Optional self-check: IMM_ENCODER_SELFCHECK_EN.
module imm_instr_encoder
  import rv32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  imm_instr_encoder_if.slave   bus,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 selfcheck_err
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_LAST = '1;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_done;
  logic [31:0]       w_pack_word;
  logic [1:0]        w_pack_err;

  imm_field_packer u_packer (
    .i_fmt      (bus.fmt),
    .i_opcode   (bus.opcode),
    .i_rd       (bus.rd),
    .i_rs1      (bus.rs1),
    .i_rs2      (bus.rs2),
    .i_funct3   (bus.funct3),
    .i_funct7   (bus.funct7),
    .i_imm      (bus.imm),
    .o_word     (w_pack_word),
    .o_err_code (w_pack_err)
  );

  // The holding stage can take a new bundle when empty or draining this cycle.
  assign w_in_ready = !r_full && (!r_wr_en || bus.wr_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_done     = r_wr_en && bus.wr_ready;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= LP_BASE;
      r_wr_data  <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_done) begin
        r_wr_en <= 1'b0;
        r_count <= r_count + 1'b1;
        // Last address saturates into full instead of wrapping.
        if (r_wr_addr == LP_LAST) r_full <= 1'b1;
        else                      r_wr_addr <= r_wr_addr + 1'b1;
      end
      if (w_accept) begin
        if (w_pack_err != ERR_NONE) begin
          r_err <= 1'b1;
          if (!r_err) r_err_code <= w_pack_err;
        end else begin
          r_wr_en   <= 1'b1;
          r_wr_data <= w_pack_word;
        end
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign count        = r_count;
  assign full         = r_full;
  assign err          = r_err;
  assign err_code     = r_err_code;

`ifdef IMM_ENCODER_SELFCHECK_EN
  logic [31:0] r_src_imm;
  logic        r_src_has_imm;
  logic        r_selfcheck_err;
  logic [31:0] w_dec_imm;

  immediate_generator u_imm_gen (
    .instr        (r_wr_data),
    .imm_extended (w_dec_imm)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_src_imm       <= '0;
      r_src_has_imm   <= 1'b0;
      r_selfcheck_err <= 1'b0;
    end else begin
      if (w_accept && w_pack_err == ERR_NONE) begin
        r_src_imm     <= bus.imm;
        r_src_has_imm <= (bus.fmt != FMT_R);
      end
      if (r_wr_en && r_src_has_imm && w_dec_imm != r_src_imm) r_selfcheck_err <= 1'b1;
    end
  end

  assign selfcheck_err = r_selfcheck_err;
`else
  assign selfcheck_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed vector table, multi-cycle
// sequences, a small-address-space instance and randomized traffic vs a reference model.
module tb_imm_instr_encoder;
  import rv32_pkg::*;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_data;
    logic [1:0]  exp_code;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, clr_a, rst_b, clr_b;
  logic [10:0] count_a;
  logic [2:0]  count_b;
  logic        full_a, err_a, sc_a, full_b, err_b, sc_b;
  logic [1:0]  code_a, code_b;

  imm_instr_encoder_if #(.ADDR_W(10)) bus_a ();
  imm_instr_encoder_if #(.ADDR_W(2))  bus_b ();

  imm_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst_a), .clr(clr_a), .bus(bus_a),
    .count(count_a), .full(full_a), .err(err_a), .err_code(code_a), .selfcheck_err(sc_a)
  );

  imm_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst_b), .clr(clr_b), .bus(bus_b),
    .count(count_b), .full(full_b), .err(err_b), .err_code(code_b), .selfcheck_err(sc_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp_data, input logic [1:0] exp_code);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_data = exp_data; v.exp_code = exp_code;
    return v;
  endfunction

  task automatic drive_a(input vec_t v);
    bus_a.fmt = v.fmt; bus_a.opcode = v.op; bus_a.rd = v.rd; bus_a.rs1 = v.rs1;
    bus_a.rs2 = v.rs2; bus_a.funct3 = v.f3; bus_a.funct7 = v.f7; bus_a.imm = v.imm;
    bus_a.in_valid = 1'b1;
  endtask

  task automatic drive_b(input vec_t v);
    bus_b.fmt = v.fmt; bus_b.opcode = v.op; bus_b.rd = v.rd; bus_b.rs1 = v.rs1;
    bus_b.rs2 = v.rs2; bus_b.funct3 = v.f3; bus_b.funct7 = v.f7; bus_b.imm = v.imm;
    bus_b.in_valid = 1'b1;
  endtask

  // Reference encoder: signed ranges checked as plain integers, immediate bits
  // placed by shifting the ISA-defined bit slices into their slots.
  function automatic void ref_encode(input vec_t v, output logic [31:0] w, output logic [1:0] c);
    longint s;
    longint lo;
    longint hi;
    bit even;
    logic [31:0] u;
    s = longint'($signed(v.imm));
    u = v.imm;
    lo = 0; hi = 0; even = 0; c = 0;
    w = (32'(v.rs1) << 15) | (32'(v.f3) << 12) | 32'(v.op);
    case (v.fmt)
      3'd0: w = w | (32'(v.f7) << 25) | (32'(v.rs2) << 20) | (32'(v.rd) << 7);
      3'd1: begin lo = -2048; hi = 2047; w = w | ((u & 32'hFFF) << 20) | (32'(v.rd) << 7); end
      3'd2: begin
        lo = -2048; hi = 2047;
        w = w | (((u >> 5) & 32'h7F) << 25) | (32'(v.rs2) << 20) | ((u & 32'h1F) << 7);
      end
      3'd3: begin
        lo = -4096; hi = 4094; even = 1;
        w = w | (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(v.rs2) << 20)
              | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
      end
      3'd4: w = (u & 32'hFFFF_F000) | (32'(v.rd) << 7) | 32'(v.op);
      3'd5: begin
        lo = -1048576; hi = 1048574; even = 1;
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
          | (((u >> 12) & 32'hFF) << 12) | (32'(v.rd) << 7) | 32'(v.op);
      end
      default: c = 2'd3;
    endcase
    if (v.fmt inside {3'd1, 3'd2, 3'd3, 3'd5}) begin
      if (s < lo || s > hi) c = 2'd1;
      else if (even && (s % 2 != 0)) c = 2'd2;
    end
    if (v.fmt == 3'd4 && u[11:0] != 12'd0) c = 2'd1;
  endfunction

  vec_t        tbl[18];
  vec_t        rv;
  logic [31:0] m_data, w_ref;
  logic [1:0]  c_ref;
  int          m_addr, m_count;
  bit          m_pend, m_full, m_err, r_clr, r_acc, r_done, exp_ready;
  logic [1:0]  m_code;

  initial begin
    tbl[0]  = mk(3'd1, 7'h13, 5, 10, 0, 3'd0, 7'h00, -32'sd50,       32'hFCE50293, 2'd0);
    tbl[1]  = mk(3'd2, 7'h23, 0, 10, 5, 3'd2, 7'h00, 32'd32,         32'h02552023, 2'd0);
    tbl[2]  = mk(3'd3, 7'h63, 0, 1,  2, 3'd0, 7'h00, -32'sd8,        32'hFE208CE3, 2'd0);
    tbl[3]  = mk(3'd4, 7'h37, 5, 0,  0, 3'd0, 7'h00, 32'hDEADB000,   32'hDEADB2B7, 2'd0);
    tbl[4]  = mk(3'd5, 7'h6F, 1, 0,  0, 3'd0, 7'h00, -32'sd32,       32'hFE1FF0EF, 2'd0);
    tbl[5]  = mk(3'd0, 7'h33, 3, 1,  2, 3'd0, 7'h20, 32'd123,        32'h402081B3, 2'd0);
    tbl[6]  = mk(3'd1, 7'h13, 1, 0,  0, 3'd0, 7'h00, -32'sd2048,     32'h80000093, 2'd0);
    tbl[7]  = mk(3'd2, 7'h23, 0, 2,  3, 3'd2, 7'h00, 32'd2047,       32'h7E312FA3, 2'd0);
    tbl[8]  = mk(3'd3, 7'h63, 0, 0,  0, 3'd0, 7'h00, 32'd4094,       32'h7E000FE3, 2'd0);
    tbl[9]  = mk(3'd5, 7'h6F, 0, 0,  0, 3'd0, 7'h00, 32'd1048574,    32'h7FFFF06F, 2'd0);
    tbl[10] = mk(3'd5, 7'h6F, 0, 0,  0, 3'd0, 7'h00, -32'sd1048576,  32'h8000006F, 2'd0);
    tbl[11] = mk(3'd1, 7'h13, 5, 1,  0, 3'd0, 7'h00, 32'd2048,       32'h0,        2'd1);
    tbl[12] = mk(3'd3, 7'h63, 0, 1,  2, 3'd0, 7'h00, -32'sd7,        32'h0,        2'd2);
    tbl[13] = mk(3'd3, 7'h63, 0, 1,  2, 3'd0, 7'h00, 32'd4095,       32'h0,        2'd1);
    tbl[14] = mk(3'd3, 7'h63, 0, 1,  2, 3'd0, 7'h00, -32'sd4098,     32'h0,        2'd1);
    tbl[15] = mk(3'd5, 7'h6F, 1, 0,  0, 3'd0, 7'h00, 32'd3,          32'h0,        2'd2);
    tbl[16] = mk(3'd4, 7'h37, 1, 0,  0, 3'd0, 7'h00, 32'h12345001,   32'h0,        2'd1);
    tbl[17] = mk(3'd6, 7'h13, 1, 0,  0, 3'd0, 7'h00, 32'd0,          32'h0,        2'd3);

    bus_a.in_valid = 0; bus_a.wr_ready = 1; bus_b.in_valid = 0; bus_b.wr_ready = 1;
    drive_a(tbl[0]); drive_b(tbl[0]);
    bus_a.in_valid = 0; bus_b.in_valid = 0;
    rst_a = 1; clr_a = 0; rst_b = 1; clr_b = 0;
    tick(); tick();
    chk("rst_wr_en", bus_a.wr_en, 0);
    chk("rst_wr_addr", bus_a.wr_addr, 0);
    chk("rst_wr_data", bus_a.wr_data, 0);
    chk("rst_count", count_a, 0);
    chk("rst_full_err", {full_a, err_a, code_a}, 0);
    rst_a = 0; rst_b = 0;
    tick();
    chk("rst_in_ready", bus_a.in_ready, 1);

    // Vector table: one isolated transaction each, cleared first so err_code is fresh.
    for (int i = 0; i < 18; i++) begin
      clr_a = 1; tick(); clr_a = 0;
      drive_a(tbl[i]);
      tick();
      bus_a.in_valid = 0;
      $display("txn tbl[%0d] fmt=%0d imm=%h wr_en=%0b wr_data=%h err_code=%0d",
               i, tbl[i].fmt, tbl[i].imm, bus_a.wr_en, bus_a.wr_data, code_a);
      chk($sformatf("tbl%0d_wr_en", i), bus_a.wr_en, (tbl[i].exp_code == 0));
      chk($sformatf("tbl%0d_err_code", i), code_a, tbl[i].exp_code);
      if (tbl[i].exp_code == 0) chk($sformatf("tbl%0d_wr_data", i), bus_a.wr_data, tbl[i].exp_data);
      else                      chk($sformatf("tbl%0d_err", i), err_a, 1);
      tick();
    end

    // Back-to-back I,S,B,U,J at consecutive addresses.
    clr_a = 1; tick(); clr_a = 0;
    for (int i = 0; i < 5; i++) begin
      drive_a(tbl[i]);
      tick();
      $display("txn b2b[%0d] wr_addr=%0d wr_data=%h count=%0d", i, bus_a.wr_addr, bus_a.wr_data, count_a);
      chk($sformatf("b2b%0d_wr_en", i), bus_a.wr_en, 1);
      chk($sformatf("b2b%0d_wr_addr", i), bus_a.wr_addr, i);
      chk($sformatf("b2b%0d_wr_data", i), bus_a.wr_data, tbl[i].exp_data);
      chk($sformatf("b2b%0d_count", i), count_a, i);
    end
    bus_a.in_valid = 0;
    tick();
    chk("b2b_final_count", count_a, 5);
    chk("b2b_final_wr_en", bus_a.wr_en, 0);

    // First error is held; clr clears it.
    clr_a = 1; tick(); clr_a = 0;
    drive_a(tbl[11]); tick();
    $display("txn err1 wr_en=%0b err=%0b err_code=%0d", bus_a.wr_en, err_a, code_a);
    chk("err1_wr_en", bus_a.wr_en, 0);
    chk("err1_err", err_a, 1);
    chk("err1_code", code_a, 1);
    drive_a(tbl[12]); tick();
    bus_a.in_valid = 0;
    $display("txn err2 wr_en=%0b err=%0b err_code=%0d", bus_a.wr_en, err_a, code_a);
    chk("err2_code_held", code_a, 1);
    chk("err2_count", count_a, 0);
    chk("err2_wr_addr", bus_a.wr_addr, 0);
    clr_a = 1; tick(); clr_a = 0;
    chk("err_clr_err", {err_a, code_a}, 0);

    // Stall: write pending with wr_ready low for three cycles.
    bus_a.wr_ready = 0;
    drive_a(tbl[0]); tick();
    drive_a(tbl[1]);
    chk("stall_wr_en0", bus_a.wr_en, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_hold", i), {bus_a.wr_en, 22'(bus_a.wr_addr), bus_a.wr_data},
          {1'b1, 22'd0, 32'hFCE50293});
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", i), bus_a.in_ready, 0);
    end
    bus_a.wr_ready = 1;
    #1;
    chk("stall_release_in_ready", bus_a.in_ready, 1);
    tick();
    bus_a.in_valid = 0;
    $display("txn stall_release wr_addr=%0d wr_data=%h count=%0d", bus_a.wr_addr, bus_a.wr_data, count_a);
    chk("stall_refill_addr", bus_a.wr_addr, 1);
    chk("stall_refill_data", bus_a.wr_data, 32'h02552023);
    chk("stall_refill_count", count_a, 1);
    tick();
    chk("stall_drain_count", count_a, 2);

    // Reset drops a pending write.
    bus_a.wr_ready = 0;
    drive_a(tbl[2]); tick();
    bus_a.in_valid = 0;
    chk("rstpend_wr_en", bus_a.wr_en, 1);
    rst_a = 1; tick(); rst_a = 0;
    chk("rstpend_dropped", bus_a.wr_en, 0);
    chk("rstpend_count", count_a, 0);
    chk("rstpend_addr", bus_a.wr_addr, 0);
    bus_a.wr_ready = 1;

    // Small address space: fill all four words, then blocked until clr.
    for (int i = 0; i < 4; i++) begin
      drive_b(tbl[i]); tick();
      chk($sformatf("fill%0d_wr_addr", i), bus_b.wr_addr, i);
    end
    bus_b.in_valid = 0;
    tick();
    $display("txn fill count=%0d full=%0b", count_b, full_b);
    chk("fill_full", full_b, 1);
    chk("fill_count", count_b, 4);
    @(negedge clk);
    chk("fill_in_ready", bus_b.in_ready, 0);
    drive_b(tbl[17]);
    tick();
    chk("full_ignore_fmt7", {err_b, bus_b.wr_en}, 0);
    bus_b.in_valid = 0;
    clr_b = 1; tick(); clr_b = 0;
    chk("fill_clr_addr", bus_b.wr_addr, 0);
    chk("fill_clr_full", full_b, 0);
    @(negedge clk);
    chk("fill_clr_in_ready", bus_b.in_ready, 1);
    tick();

    // Randomized traffic against the reference model.
    clr_a = 1; tick(); clr_a = 0;
    m_pend = 0; m_full = 0; m_err = 0; m_code = 0; m_addr = 0; m_count = 0; m_data = 0;
    for (int n = 0; n < 3000; n++) begin
      rv.fmt = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      rv.op = 7'($urandom); rv.rd = 5'($urandom); rv.rs1 = 5'($urandom);
      rv.rs2 = 5'($urandom); rv.f3 = 3'($urandom); rv.f7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0:       rv.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1:       rv.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
        2:       rv.imm = $urandom & 32'hFFFF_F000;
        default: rv.imm = $urandom;
      endcase
      drive_a(rv);
      bus_a.in_valid = ($urandom_range(0, 9) < 7);
      bus_a.wr_ready = ($urandom_range(0, 9) < 7);
      r_clr = ($urandom_range(0, 199) == 0);
      clr_a = r_clr;
      @(negedge clk);
      exp_ready = !m_full && (!m_pend || bus_a.wr_ready);
      chk("rnd_in_ready", bus_a.in_ready, exp_ready);
      r_acc = bus_a.in_valid && exp_ready;
      r_done = m_pend && bus_a.wr_ready;
      tick();
      if (r_clr) begin
        m_pend = 0; m_full = 0; m_err = 0; m_code = 0; m_addr = 0; m_count = 0;
      end else begin
        if (r_done) begin
          m_count++;
          m_pend = 0;
          if (m_addr == 1023) m_full = 1;
          else m_addr++;
        end
        if (r_acc) begin
          ref_encode(rv, w_ref, c_ref);
          if (c_ref != 0) begin
            if (!m_err) m_code = c_ref;
            m_err = 1;
          end else begin
            m_pend = 1;
            m_data = w_ref;
          end
        end
      end
      chk("rnd_wr_en", bus_a.wr_en, m_pend);
      if (m_pend) begin
        chk("rnd_wr_addr", bus_a.wr_addr, m_addr);
        chk("rnd_wr_data", bus_a.wr_data, m_data);
      end
      chk("rnd_count", count_a, m_count);
      chk("rnd_flags", {full_a, err_a, code_a}, {m_full, m_err, m_code});
    end
    clr_a = 0;
    bus_a.in_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
